reg_dump_unit: RTL

- Hardware end-of-run register snapshot engine for the MIPS core.
- Detects program completion by one of three triggers: PC stable for N cycles, a cycle-count timeout, or a forced request.
- On completion it captures the final PC and streams PC plus every register-file entry out over a valid/ready port.
- Sits beside the register file on a dedicated read port; feeds benches, a UART bridge or a trace buffer.

---
 rtl/mips_dbg_pkg.sv | 26 ++
 rtl/reg_dump_unit_halt_detect.sv | 107 ++++++++++
 rtl/reg_dump_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug/snapshot blocks: FSM state encoding,
// halt cause codes and default data/index widths.
package mips_dbg_pkg;

    localparam int DBG_DATA_W = 32;
    localparam int DBG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } dump_state_e;

    typedef logic [1:0] halt_cause_t;

    localparam halt_cause_t HALT_NONE    = 2'd0;
    localparam halt_cause_t HALT_TIMEOUT = 2'd1;
    localparam halt_cause_t HALT_STABLE  = 2'd2;
    localparam halt_cause_t HALT_FORCED  = 2'd3;

    function automatic logic state_is_busy(input dump_state_e s);
        return (s == RUN) || (s == DUMP);
    endfunction

endpackage

// File: rtl/reg_dump_unit_halt_detect.sv
// Program-completion detector: saturating cycle and PC-stable counters plus
// prioritised trigger (forced > pc_stable > timeout) and cause encoding.
module halt_detect
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W         = DBG_DATA_W,
    parameter int TIMEOUT_CYCLES = 4100,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_run,
    input  logic              i_force,
    input  logic [DATA_W-1:0] i_pc,
    output logic              o_trigger,
    output halt_cause_t       o_cause
);

    localparam int CYC_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [CYC_W-1:0] CYC_ZERO  = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_MAX   = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_LIMIT = TO_EN ? CYC_W'(TIMEOUT_CYCLES - 1) : CYC_MAX;
    localparam logic [STB_W-1:0] STB_ZERO  = {STB_W{1'b0}};
    localparam logic [STB_W-1:0] STB_ONE   = STB_W'(1);
    localparam logic [STB_W-1:0] STB_MAX   = {STB_W{1'b1}};
    localparam logic [STB_W-1:0] STB_LIMIT = STB_W'(STABLE_CYCLES);

    logic [CYC_W-1:0]  r_cyc;
    logic [STB_W-1:0]  r_stable;
    logic [DATA_W-1:0] r_prev_pc;

    logic [CYC_W-1:0]  w_cyc_next;
    logic [STB_W-1:0]  w_stable_next;
    logic              w_hit_stable;
    logic              w_hit_timeout;

    // Next values of the saturating counters and the raw trigger conditions.
    always_comb begin
        w_cyc_next    = (r_cyc == CYC_MAX) ? CYC_MAX : (r_cyc + CYC_ONE);
        w_stable_next = STB_ONE;
        if (i_pc != r_prev_pc) begin
            w_stable_next = STB_ONE;
        end else if (r_stable == STB_MAX) begin
            w_stable_next = STB_MAX;
        end else begin
            w_stable_next = r_stable + STB_ONE;
        end
        // The stable count is judged on this cycle's updated value so that a PC
        // held for STABLE_CYCLES consecutive cycles triggers on the last of them.
        w_hit_stable  = (w_stable_next == STB_LIMIT);
        w_hit_timeout = TO_EN && (r_cyc == CYC_LIMIT);
    end

    // Trigger priority and cause encoding, only meaningful while running.
    always_comb begin
        o_trigger = 1'b0;
        o_cause   = HALT_NONE;
        if (!i_run) begin
            o_trigger = 1'b0;
            o_cause   = HALT_NONE;
        end else if (i_force) begin
            o_trigger = 1'b1;
            o_cause   = HALT_FORCED;
        end else if (w_hit_stable) begin
            o_trigger = 1'b1;
            o_cause   = HALT_STABLE;
        end else if (w_hit_timeout) begin
            o_trigger = 1'b1;
            o_cause   = HALT_TIMEOUT;
        end else begin
            o_trigger = 1'b0;
            o_cause   = HALT_NONE;
        end
    end

    // Previous-cycle PC for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_pc <= {DATA_W{1'b0}};
        end else begin
            r_prev_pc <= i_pc;
        end
    end

    // Cycle and stable counters: cleared on arm, advanced while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc    <= CYC_ZERO;
            r_stable <= STB_ZERO;
        end else if (i_clear) begin
            r_cyc    <= CYC_ZERO;
            r_stable <= STB_ZERO;
        end else if (i_run) begin
            r_cyc    <= w_cyc_next;
            r_stable <= w_stable_next;
        end else begin
            r_cyc    <= r_cyc;
            r_stable <= r_stable;
        end
    end

endmodule

// File: rtl/reg_dump_unit.sv
// End-of-run register snapshot engine: waits for a halt trigger, then streams
// the final PC and every register-file entry over a valid/ready port.
module reg_dump_unit
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W         = DBG_DATA_W,
    parameter int NUM_REGS       = 32,
    parameter int ADDR_W         = DBG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 4100,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              force_dump,
    input  logic [DATA_W-1:0] pc_in,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_is_pc,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        halt_cause
);

    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

    dump_state_e       r_state;
    dump_state_e       w_state_next;

    logic              r_dump_valid;
    logic              r_dump_is_pc;
    logic [ADDR_W-1:0] r_dump_idx;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_last;
    logic [ADDR_W-1:0] r_next_idx;
    logic              r_more;
    logic              r_busy;
    logic              r_done;
    halt_cause_t       r_halt_cause;

    logic              w_arm_ok;
    logic              w_run;
    logic              w_load;
    logic              w_dump_end;
    logic              w_trigger;
    halt_cause_t       w_cause;

    assign w_arm_ok   = arm && ((r_state == IDLE) || (r_state == DONE));
    assign w_run      = (r_state == RUN);
    assign w_load     = !r_dump_valid || dump_ready;
    // With no registers left to load, the beat on the port is the last one.
    assign w_dump_end = (r_state == DUMP) && w_load && !r_more;

    halt_detect #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .STABLE_CYCLES  (STABLE_CYCLES)
    ) u_halt_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_arm_ok),
        .i_run     (w_run),
        .i_force   (force_dump),
        .i_pc      (pc_in),
        .o_trigger (w_trigger),
        .o_cause   (w_cause)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (arm) w_state_next = RUN;
                else     w_state_next = IDLE;
            end
            RUN: begin
                if (w_trigger) w_state_next = DUMP;
                else           w_state_next = RUN;
            end
            DUMP: begin
                if (w_dump_end) w_state_next = DONE;
                else            w_state_next = DUMP;
            end
            DONE: begin
                if (arm) w_state_next = RUN;
                else     w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output stage: PC beat loaded on the trigger, then one register per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dump_valid <= 1'b0;
            r_dump_is_pc <= 1'b0;
            r_dump_idx   <= IDX_ZERO;
            r_dump_data  <= {DATA_W{1'b0}};
            r_dump_last  <= 1'b0;
            r_next_idx   <= IDX_ZERO;
            r_more       <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_trigger) begin
                        r_dump_valid <= 1'b1;
                        r_dump_is_pc <= 1'b1;
                        r_dump_idx   <= IDX_ZERO;
                        r_dump_data  <= pc_in;
                        r_dump_last  <= 1'b0;
                        r_next_idx   <= IDX_ZERO;
                        r_more       <= 1'b1;
                    end else begin
                        r_dump_valid <= r_dump_valid;
                    end
                end
                DUMP: begin
                    if (w_load && r_more) begin
                        r_dump_valid <= 1'b1;
                        r_dump_is_pc <= 1'b0;
                        r_dump_idx   <= r_next_idx;
                        r_dump_data  <= rf_rd_data;
                        r_dump_last  <= (r_next_idx == IDX_LAST);
                        r_more       <= (r_next_idx != IDX_LAST);
                        // Address parks on the final index once it has been read.
                        r_next_idx   <= (r_next_idx == IDX_LAST) ? r_next_idx : (r_next_idx + IDX_ONE);
                    end else if (w_load) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                    end else begin
                        r_dump_valid <= r_dump_valid;
                    end
                end
                default: begin
                    r_dump_valid <= r_dump_valid;
                end
            endcase
        end
    end

    // Status flags and the latched halt cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_halt_cause <= HALT_NONE;
        end else begin
            r_busy <= state_is_busy(w_state_next);
            r_done <= (w_state_next == DONE);
            if (w_arm_ok) begin
                r_halt_cause <= HALT_NONE;
            end else if (w_run && w_trigger) begin
                r_halt_cause <= w_cause;
            end else begin
                r_halt_cause <= r_halt_cause;
            end
        end
    end

    assign rf_rd_addr = r_next_idx;
    assign dump_valid = r_dump_valid;
    assign dump_is_pc = r_dump_is_pc;
    assign dump_idx   = r_dump_idx;
    assign dump_data  = r_dump_data;
    assign dump_last  = r_dump_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign halt_cause = r_halt_cause;

endmodule
